// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the polyphase FIR family (interpolator, decimator).
// Helpers work on a 128-bit signed container so one copy serves any DATA_WIDTH up to 64.
package fir_pkg;

    typedef enum logic [1:0] {LOAD, MAC, EMIT} state_t;

    localparam int WIDE_W = 128;
    typedef logic signed [WIDE_W-1:0] wide_t;

    // Divide by 2^frac rounding toward zero; a bare >>> would round negative products down.
    function automatic wide_t dequant(input wide_t prod, input int frac);
        wide_t bias;
        bias = '0;
        if (prod[WIDE_W-1])
            bias = (wide_t'(1) <<< frac) - wide_t'(1);
        return (prod + bias) >>> frac;
    endfunction

    function automatic wide_t saturate(input wide_t v, input int width);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (width - 1));
        if (v > hi)
            return hi;
        if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// One MAC slice: MULT_PER_CYCLE full-width products, each dequantized, summed to one partial sum.
// FIR_INTERP_SAT_EN selects saturating arithmetic; otherwise results wrap to DATA_WIDTH bits.
module fir_mac_lane
    import fir_pkg::*;
#(
    parameter int MULT_PER_CYCLE = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int FRAC_BITS      = 10
) (
    input  logic signed [DATA_WIDTH-1:0] coef [MULT_PER_CYCLE],
    input  logic signed [DATA_WIDTH-1:0] samp [MULT_PER_CYCLE],
    output logic signed [DATA_WIDTH-1:0] psum
);

    logic signed [2*DATA_WIDTH-1:0] prod [MULT_PER_CYCLE];
    wide_t                          term [MULT_PER_CYCLE];
    wide_t                          sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < MULT_PER_CYCLE; i++) begin
            prod[i] = (2*DATA_WIDTH)'(coef[i]) * (2*DATA_WIDTH)'(samp[i]);
            term[i] = dequant(wide_t'(prod[i]), FRAC_BITS);
`ifdef FIR_INTERP_SAT_EN
            term[i] = saturate(term[i], DATA_WIDTH);
`endif
            sum = sum + term[i];
        end
        // Low bits of the wide sum equal the modular sum of each term's low bits.
`ifdef FIR_INTERP_SAT_EN
        psum = DATA_WIDTH'(saturate(sum, DATA_WIDTH));
`else
        psum = sum[DATA_WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/fir_interp.sv
// Polyphase interpolating FIR: each popped input yields INTERP_FACTOR outputs via a time-shared MAC.
// Optional FIR_INTERP_SAT_EN: saturating dequant and accumulate instead of wrap-around.
module fir_interp
    import fir_pkg::*;
#(
    parameter int TAP_COUNT      = 32,
    parameter int INTERP_FACTOR  = 2,
    parameter int MULT_PER_CYCLE = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int FRAC_BITS      = 10,
    parameter logic [0:TAP_COUNT-1][DATA_WIDTH-1:0] TAPS = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] in_dout,
    input  logic                         in_empty,
    output logic                         in_rd_en,
    output logic signed [DATA_WIDTH-1:0] out_data,
    input  logic                         out_full,
    output logic                         out_wr_en
);

    localparam int PHASE_TAPS = TAP_COUNT / INTERP_FACTOR;
    localparam int MAC_CYCLES = PHASE_TAPS / MULT_PER_CYCLE;
    localparam int PH_W       = (INTERP_FACTOR > 1) ? $clog2(INTERP_FACTOR) : 1;
    localparam int MC_W       = (MAC_CYCLES > 1) ? $clog2(MAC_CYCLES) : 1;
    localparam int HIST_IW    = (PHASE_TAPS > 1) ? $clog2(PHASE_TAPS) : 1;
    localparam int TAP_IW     = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1;

    generate
        if (INTERP_FACTOR < 1 || TAP_COUNT < 1 || MULT_PER_CYCLE < 1 ||
            (TAP_COUNT % INTERP_FACTOR) != 0 || (PHASE_TAPS % MULT_PER_CYCLE) != 0) begin : g_bad_params
            $error("fir_interp: TAP_COUNT must be a multiple of INTERP_FACTOR and MULT_PER_CYCLE must divide TAP_COUNT/INTERP_FACTOR");
        end
    endgenerate

    state_t                         state;
    state_t                         state_nxt;
    logic signed [DATA_WIDTH-1:0]   hist [PHASE_TAPS];
    logic        [PH_W-1:0]         phase;
    logic        [MC_W-1:0]         mac_cnt;
    logic signed [DATA_WIDTH-1:0]   acc;
    logic signed [DATA_WIDTH-1:0]   acc_nxt;
    logic signed [DATA_WIDTH-1:0]   psum;
    logic signed [DATA_WIDTH-1:0]   lane_coef [MULT_PER_CYCLE];
    logic signed [DATA_WIDTH-1:0]   lane_samp [MULT_PER_CYCLE];
    logic        [HIST_IW-1:0]      hist_idx  [MULT_PER_CYCLE];
    logic        [TAP_IW-1:0]       tap_idx   [MULT_PER_CYCLE];
    logic                           mac_last;
    logic                           last_phase;

    assign mac_last   = (mac_cnt == MC_W'(MAC_CYCLES - 1));
    assign last_phase = (phase == PH_W'(INTERP_FACTOR - 1));

    // Handshakes are gated by reset so nothing moves while it is held.
    assign in_rd_en  = reset && (state == LOAD) && !in_empty;
    assign out_wr_en = reset && (state == EMIT) && !out_full;

    // Lane j of this MAC cycle pairs hist[j] with the phase's j-th polyphase coefficient.
    always_comb begin
        for (int i = 0; i < MULT_PER_CYCLE; i++) begin
            hist_idx[i]  = HIST_IW'(int'(mac_cnt) * MULT_PER_CYCLE + i);
            tap_idx[i]   = TAP_IW'(int'(phase) + (int'(mac_cnt) * MULT_PER_CYCLE + i) * INTERP_FACTOR);
            lane_coef[i] = TAPS[tap_idx[i]];
            lane_samp[i] = hist[hist_idx[i]];
        end
    end

    fir_mac_lane #(
        .MULT_PER_CYCLE (MULT_PER_CYCLE),
        .DATA_WIDTH     (DATA_WIDTH),
        .FRAC_BITS      (FRAC_BITS)
    ) u_lane (
        .coef (lane_coef),
        .samp (lane_samp),
        .psum (psum)
    );

`ifdef FIR_INTERP_SAT_EN
    assign acc_nxt = DATA_WIDTH'(saturate(wide_t'(acc) + wide_t'(psum), DATA_WIDTH));
`else
    assign acc_nxt = acc + psum;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (!in_empty) state_nxt = MAC;
            MAC:     if (mac_last) state_nxt = EMIT;
            EMIT:    if (!out_full) state_nxt = last_phase ? LOAD : MAC;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < PHASE_TAPS; k++)
                hist[k] <= '0;
            phase    <= '0;
            mac_cnt  <= '0;
            acc      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_rd_en) begin
                        for (int k = PHASE_TAPS - 1; k > 0; k--)
                            hist[k] <= hist[k-1];
                        hist[0] <= in_dout;
                        phase   <= '0;
                        acc     <= '0;
                        mac_cnt <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_nxt;
                    if (mac_last) begin
                        mac_cnt  <= '0;
                        out_data <= acc_nxt;
                    end else begin
                        mac_cnt <= mac_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_wr_en && !last_phase) begin
                        phase   <= phase + 1'b1;
                        acc     <= '0;
                        mac_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_interp.sv
// Bench for fir_interp: reset, starvation, impulse, backpressure, truncation, overflow, mid-run reset.
`timescale 1ns/1ps
module tb_fir_interp;

    localparam int TC  = 8;
    localparam int L   = 2;
    localparam int MPC = 2;
    localparam int W   = 32;
    localparam int F   = 10;
    localparam int M   = TC / L / MPC;

    localparam logic [0:TC-1][W-1:0] TAPS_IMP = {32'd1024, 32'd2048, 32'd3072, 32'd4096,
                                                 32'd5120, 32'd6144, 32'd7168, 32'd8192};
    localparam logic [0:TC-1][W-1:0] TAPS_TRN = {32'hFFFF_FFFF, 224'd0};
    localparam logic [0:TC-1][W-1:0] TAPS_OVF = {32'h0020_0000, 224'd0};
`ifdef FIR_INTERP_SAT_EN
    localparam logic [W-1:0] OVF_EXP = 32'h7FFF_FFFF;
`else
    localparam logic [W-1:0] OVF_EXP = 32'h8000_0000;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [W-1:0] a_din, a_out, b_din, b_out, c_din, c_out;
    logic a_empty, a_rd, a_full, a_wr;
    logic b_empty, b_rd, b_full, b_wr;
    logic c_empty, c_rd, c_full, c_wr;

    fir_interp #(.TAP_COUNT(TC), .INTERP_FACTOR(L), .MULT_PER_CYCLE(MPC), .DATA_WIDTH(W),
                 .FRAC_BITS(F), .TAPS(TAPS_IMP)) dut_a (
        .clock(clock), .reset(reset), .in_dout(a_din), .in_empty(a_empty), .in_rd_en(a_rd),
        .out_data(a_out), .out_full(a_full), .out_wr_en(a_wr));

    fir_interp #(.TAP_COUNT(TC), .INTERP_FACTOR(L), .MULT_PER_CYCLE(MPC), .DATA_WIDTH(W),
                 .FRAC_BITS(F), .TAPS(TAPS_TRN)) dut_b (
        .clock(clock), .reset(reset), .in_dout(b_din), .in_empty(b_empty), .in_rd_en(b_rd),
        .out_data(b_out), .out_full(b_full), .out_wr_en(b_wr));

    fir_interp #(.TAP_COUNT(TC), .INTERP_FACTOR(L), .MULT_PER_CYCLE(MPC), .DATA_WIDTH(W),
                 .FRAC_BITS(F), .TAPS(TAPS_OVF)) dut_c (
        .clock(clock), .reset(reset), .in_dout(c_din), .in_empty(c_empty), .in_rd_en(c_rd),
        .out_data(c_out), .out_full(c_full), .out_wr_en(c_wr));

    logic [W-1:0] in_q[$];
    logic [W-1:0] exp_q[$];
    int           pop_cyc[$];
    int           wr_cyc[$];
    int           checks = 0;
    int           failures = 0;
    int           cycle = 0;
    int           overlap = 0;
    logic         last_rd, last_wr, last_b_rd;
    logic [W-1:0] last_out;
    logic [W-1:0] b_first, c_first;
    logic         b_got = 1'b0;
    logic         c_got = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic drive_fifo();
        a_empty = (in_q.size() == 0);
        a_din   = (in_q.size() != 0) ? in_q[0] : '0;
    endtask

    task automatic push_impulse();
        in_q = {32'd1024, 32'd0, 32'd0, 32'd0, 32'd0};
        exp_q = {32'd1024, 32'd2048, 32'd3072, 32'd4096, 32'd5120,
                 32'd6144, 32'd7168, 32'd8192, 32'd0, 32'd0};
        drive_fifo();
    endtask

    // One clock: sample outputs on the falling edge, update FIFO models just after the rising edge.
    task automatic step();
        logic b_pop, c_pop;
        @(negedge clock);
        last_rd = a_rd; last_wr = a_wr; last_out = a_out; last_b_rd = b_rd;
        b_pop = b_rd; c_pop = c_rd;
        if (a_rd && a_wr) overlap++;
        if (a_wr) begin
            wr_cyc.push_back(cycle);
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_write: observed=0x%08h expected=no write", a_out);
            end
            if (exp_q.size() != 0) chk("out_data", a_out, exp_q.pop_front());
        end
        if (a_rd) pop_cyc.push_back(cycle);
        if (b_wr && !b_got) begin b_got = 1'b1; b_first = b_out; end
        if (c_wr && !c_got) begin c_got = 1'b1; c_first = c_out; end
        @(posedge clock);
        #1;
        cycle++;
        if (last_rd && in_q.size() != 0) void'(in_q.pop_front());
        if (b_pop) b_empty = 1'b1;
        if (c_pop) c_empty = 1'b1;
        drive_fifo();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL %s_timeout: pending=%0d expected=0", tag, exp_q.size());
        end
        repeat (6) step();
    endtask

    initial begin
        int n;
        a_full = 1'b0; b_full = 1'b0; c_full = 1'b0;
        b_din = 32'd1023; b_empty = 1'b0;
        c_din = 32'h0010_0000; c_empty = 1'b0;
        drive_fifo();
        #2 reset = 1'b0;

        // Reset: outputs cleared, read gated even though B's FIFO has data.
        repeat (3) step();
        chk("rst_out_data", last_out, 32'd0);
        chk("rst_wr_en", {31'd0, last_wr}, 32'd0);
        chk("rst_rd_en_gated", {31'd0, last_b_rd}, 32'd0);
        reset = 1'b1;

        // Starvation on A.
        repeat (20) step();
        chk("starve_rd_en", pop_cyc.size(), 0);
        chk("starve_wr_en", wr_cyc.size(), 0);

        // Impulse; the first pop must be immediate, showing the block idled in LOAD.
        push_impulse();
        step();
        chk("load_ready_pop", pop_cyc.size(), 1);
        drain("impulse", 200);
        chk("first_latency", (wr_cyc.size() > 0 && pop_cyc.size() > 0) ? wr_cyc[0] - pop_cyc[0] : -1, M + 1);
        chk("input_period", (pop_cyc.size() > 1) ? pop_cyc[1] - pop_cyc[0] : -1, L * (M + 1) + 1);
        chk("impulse_writes", wr_cyc.size(), 10);
        chk("trunc_seen", {31'd0, b_got}, 32'd1);
        chk("trunc_toward_zero", b_first, 32'd0);
        chk("ovf_seen", {31'd0, c_got}, 32'd1);
        chk("ovf_value", c_first, OVF_EXP);

        // Backpressure during the first EMIT.
        pop_cyc.delete(); wr_cyc.delete();
        a_full = 1'b1;
        push_impulse();
        n = 0;
        while (pop_cyc.size() == 0 && n < 20) begin step(); n++; end
        chk("bp_first_pop", pop_cyc.size(), 1);
        repeat (M) step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_wr_en_low", {31'd0, last_wr}, 32'd0);
            chk("bp_rd_en_low", {31'd0, last_rd}, 32'd0);
            chk("bp_out_stable", last_out, 32'd1024);
        end
        a_full = 1'b0;
        drain("backpressure", 200);
        chk("bp_writes", wr_cyc.size(), 10);

        // Reset during MAC of the second sample, then replay.
        pop_cyc.delete(); wr_cyc.delete();
        in_q = {32'd1024, 32'd0};
        exp_q = {32'd1024, 32'd2048};
        drive_fifo();
        n = 0;
        while (pop_cyc.size() < 2 && n < 60) begin step(); n++; end
        chk("rstmid_second_pop", pop_cyc.size(), 2);
        chk("rstmid_pending", exp_q.size(), 0);
        reset = 1'b0;
        in_q.push_back(32'd7777);
        drive_fifo();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rstmid_wr_en", {31'd0, last_wr}, 32'd0);
            chk("rstmid_rd_en", {31'd0, last_rd}, 32'd0);
        end
        chk("rstmid_out_data", last_out, 32'd0);
        in_q.delete();
        drive_fifo();
        reset = 1'b1;
        wr_cyc.delete();
        push_impulse();
        drain("reset_replay", 200);
        chk("replay_writes", wr_cyc.size(), 10);

        chk("no_rd_wr_overlap", overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
